// File: rtl/fp_alu_seq_ctrl_pkg.sv
// Shared types and constants for the byte-serial FP ALU sequencer.
//   state_e : 4-bit state codes exported on the status pins
//   OP_*    : opcode encodings forwarded unmodified to the core
//   QNAN    : canonical quiet NaN used as the timeout result
package fp_alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned TCNT_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 4'd0,
        S_LOAD_A = 4'd1,
        S_LOAD_B = 4'd2,
        S_ISSUE  = 4'd3,
        S_WAIT   = 4'd4,
        S_OUT    = 4'd5
    } state_e;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_MUL = 2'b10;
    localparam logic [OP_W-1:0] OP_DIV = 2'b11;

    localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fp_alu_seq_ctrl_if.sv
// Parallel bus between the sequencer and the FP ALU core.
//   master : sequencer side (drives operands, opcode, start; receives result)
//   slave  : core side
interface fp_alu_seq_ctrl_if;
    import fp_alu_pkg::*;

    logic [DATA_W-1:0] core_a;
    logic [DATA_W-1:0] core_b;
    logic [OP_W-1:0]   core_op;
    logic              core_start;
    logic [DATA_W-1:0] core_result;
    logic              core_valid;

    modport master (
        output core_a, core_b, core_op, core_start,
        input  core_result, core_valid
    );

    modport slave (
        input  core_a, core_b, core_op, core_start,
        output core_result, core_valid
    );
endinterface

// File: rtl/fp_alu_seq_ctrl_byte_shift_reg32.sv
// 32-bit MSB-first byte shift register with parallel load.
//   clk, rst_n : clock, async active-low reset (clears q)
//   load       : parallel load of load_val (wins over shift)
//   load_val   : parallel load data
//   shift      : shift q left by one byte, sin enters at the LSB byte
//   sin        : serial input byte
//   q          : register contents
module byte_shift_reg32
    import fp_alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              shift,
    input  logic [BYTE_W-1:0] sin,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {q[DATA_W-BYTE_W-1:0], sin};
        end
    end

endmodule

// File: rtl/fp_alu_seq_ctrl.sv
// Byte-serial sequencer in front of the 32-bit FP ALU core.
//   clk, rst_n : clock, async active-low reset
//   in         : operand byte, MSB first, A then B
//   opcode     : operation select, latched when a transaction starts
//   start      : level request, sampled only in IDLE
//   out, done  : result byte stream, done high for the 4 result bytes
//   state      : current state code
//   core       : parallel bus to the FP ALU core
module fp_alu_seq_ctrl
    import fp_alu_pkg::*;
#(
    parameter int unsigned       TIMEOUT    = 64,
    parameter logic [DATA_W-1:0] ERR_RESULT = QNAN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BYTE_W-1:0]   in,
    input  logic [OP_W-1:0]     opcode,
    input  logic                start,
    output logic [BYTE_W-1:0]   out,
    output logic                done,
    output logic [STATE_W-1:0]  state,
    fp_alu_seq_ctrl_if.master   core
);

    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              cstart_q, cstart_d;
    logic              done_q, done_d;

    logic              shift_a, shift_b;
    logic              res_load, res_shift;
    logic [DATA_W-1:0] res_val;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic              unused_res;

    // Operand assembly and result serialisation
    byte_shift_reg32 u_a (
        .clk(clk), .rst_n(rst_n), .load(1'b0), .load_val('0),
        .shift(shift_a), .sin(in), .q(a_q)
    );

    byte_shift_reg32 u_b (
        .clk(clk), .rst_n(rst_n), .load(1'b0), .load_val('0),
        .shift(shift_b), .sin(in), .q(b_q)
    );

    // Zeros shift in behind the result, so out returns to 0 after the 4th byte
    byte_shift_reg32 u_res (
        .clk(clk), .rst_n(rst_n), .load(res_load), .load_val(res_val),
        .shift(res_shift), .sin('0), .q(res_q)
    );

    // State and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            bcnt_q   <= '0;
            tcnt_q   <= '0;
            op_q     <= '0;
            cstart_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            tcnt_q   <= tcnt_d;
            op_q     <= op_d;
            cstart_q <= cstart_d;
            done_q   <= done_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        tcnt_d    = tcnt_q;
        op_d      = op_q;
        cstart_d  = 1'b0;
        done_d    = 1'b0;
        shift_a   = 1'b0;
        shift_b   = 1'b0;
        res_load  = 1'b0;
        res_shift = 1'b0;
        // A valid on the timeout edge takes priority over the error value
        res_val   = core.core_valid ? core.core_result : ERR_RESULT;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = opcode;
                    bcnt_d  = '0;
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                shift_a = 1'b1;
                bcnt_d  = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                shift_b = 1'b1;
                bcnt_d  = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    cstart_d = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core.core_valid || (tcnt_q == TCNT_LAST)) begin
                    res_load = 1'b1;
                    done_d   = 1'b1;
                    bcnt_d   = '0;
                    state_d  = S_OUT;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            S_OUT: begin
                res_shift = 1'b1;
                bcnt_d    = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    state_d = S_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out             = res_q[DATA_W-1 -: BYTE_W];
    assign done            = done_q;
    assign state           = state_q;
    assign core.core_a     = a_q;
    assign core.core_b     = b_q;
    assign core.core_op    = op_q;
    assign core.core_start = cstart_q;

    // Lower result bytes are only consumed through the shift path
    assign unused_res = ^res_q[DATA_W-BYTE_W-1:0];

endmodule
